// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time reader: register indices, error codes,
// sequencer states and BCD field limits. RTC_TIME_READER_DATE_EN enables the date registers.
package rtc_pkg;

  localparam logic [2:0] REG_SEC   = 3'd0;
  localparam logic [2:0] REG_MIN   = 3'd1;
  localparam logic [2:0] REG_HOUR  = 3'd2;
  localparam logic [2:0] REG_DAY   = 3'd3;
  localparam logic [2:0] REG_DATE  = 3'd4;
  localparam logic [2:0] REG_MONTH = 3'd5;
  localparam logic [2:0] REG_YEAR  = 3'd6;

`ifdef RTC_TIME_READER_DATE_EN
  localparam logic [2:0] LAST_IDX = REG_YEAR;
`else
  localparam logic [2:0] LAST_IDX = REG_HOUR;
`endif

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Bit 7 of seconds is the clock-halt flag, bit 7 of minutes and month carry no time data.
  localparam logic [7:0] SEC_MASK     = 8'h7F;
  localparam logic [7:0] MIN_MASK     = 8'h7F;
  localparam logic [7:0] MONTH_MASK   = 8'h7F;
  localparam int         CH_BIT       = 7;
  localparam int         HOUR_12H_BIT = 6;

  localparam logic [6:0] SEC_MAX   = 7'd59;
  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [6:0] HOUR_MAX  = 7'd23;
  localparam logic [6:0] DAY_MIN   = 7'd1;
  localparam logic [6:0] DAY_MAX   = 7'd7;
  localparam logic [6:0] DATE_MIN  = 7'd1;
  localparam logic [6:0] DATE_MAX  = 7'd31;
  localparam logic [6:0] MONTH_MIN = 7'd1;
  localparam logic [6:0] MONTH_MAX = 7'd12;
  localparam logic [6:0] YEAR_MAX  = 7'd99;

  function automatic logic in_range(input logic [6:0] v, input logic [6:0] lo, input logic [6:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rtc_bcd_decode.sv
// Combinational two-digit BCD to binary converter; flags either nibble above 9.
module rtc_bcd_decode (
  input  logic [7:0] i_bcd,
  output logic [6:0] o_bin,
  output logic       o_invalid
);

  logic [6:0] w_tens;
  logic [6:0] w_units;

  assign w_tens    = {3'b000, i_bcd[7:4]};
  assign w_units   = {3'b000, i_bcd[3:0]};
  assign o_bin     = (w_tens * 7'd10) + w_units;
  assign o_invalid = (i_bcd[7:4] > 4'd9) || (i_bcd[3:0] > 4'd9);

endmodule

// File: rtl/rtc_time_reader.sv
// Periodic / on-demand reader of the RTC time registers over the shared I2C byte master.
// Define RTC_TIME_READER_DATE_EN to also read and publish day, date, month and year.
module rtc_time_reader
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [6:0]  DEV_ADDR       = 7'h68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       i2c_req,
  output logic [6:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [7:0] i2c_rdata,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       clock_halt,
  output logic       time_valid,
  output logic       busy,
  output logic       err,
`ifdef RTC_TIME_READER_DATE_EN
  output logic [2:0] day,
  output logic [4:0] date,
  output logic [3:0] month,
  output logic [6:0] year,
`endif
  output logic [1:0] err_code
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_refresh_cnt;
  logic [31:0] r_to_cnt;
  logic [2:0]  r_idx;
  logic [1:0]  r_err_pend;
  logic [7:0]  r_sh_sec, r_sh_min, r_sh_hour;

  logic        w_trigger, w_timeout, w_last, w_invalid, w_time_bad, w_date_bad;
  logic        w_req_nxt, w_busy_nxt, w_tv_nxt, w_err_nxt;
  logic [6:0]  w_sec_bin, w_min_bin, w_hour_bin;
  logic        w_sec_inv, w_min_inv, w_hour_inv;

  logic        r_i2c_req, r_busy, r_time_valid, r_err, r_clock_halt;
  logic [7:0]  r_reg_addr;
  logic [5:0]  r_sec, r_min;
  logic [4:0]  r_hour;
  logic [1:0]  r_err_code;

  assign w_trigger = start | ((REFRESH_CYCLES != 32'd0) && (r_refresh_cnt == (REFRESH_CYCLES - 32'd1)));
  assign w_timeout = (r_to_cnt == (TIMEOUT_CYCLES - 32'd1));
  assign w_last    = (r_idx == LAST_IDX);

  rtc_bcd_decode u_dec_sec  (.i_bcd(r_sh_sec & SEC_MASK), .o_bin(w_sec_bin),  .o_invalid(w_sec_inv));
  rtc_bcd_decode u_dec_min  (.i_bcd(r_sh_min & MIN_MASK), .o_bin(w_min_bin),  .o_invalid(w_min_inv));
  rtc_bcd_decode u_dec_hour (.i_bcd(r_sh_hour),           .o_bin(w_hour_bin), .o_invalid(w_hour_inv));

  // 12-hour mode is rejected rather than converted.
  assign w_time_bad = w_sec_inv | w_min_inv | w_hour_inv | r_sh_hour[HOUR_12H_BIT]
                    | (w_sec_bin > SEC_MAX) | (w_min_bin > MIN_MAX) | (w_hour_bin > HOUR_MAX);

`ifdef RTC_TIME_READER_DATE_EN
  logic [7:0] r_sh_day, r_sh_date, r_sh_month, r_sh_year;
  logic [6:0] w_day_bin, w_date_bin, w_month_bin, w_year_bin;
  logic       w_day_inv, w_date_inv, w_month_inv, w_year_inv;
  logic [2:0] r_day;
  logic [4:0] r_date;
  logic [3:0] r_month;
  logic [6:0] r_year;

  rtc_bcd_decode u_dec_day   (.i_bcd(r_sh_day),                .o_bin(w_day_bin),   .o_invalid(w_day_inv));
  rtc_bcd_decode u_dec_date  (.i_bcd(r_sh_date),               .o_bin(w_date_bin),  .o_invalid(w_date_inv));
  rtc_bcd_decode u_dec_month (.i_bcd(r_sh_month & MONTH_MASK), .o_bin(w_month_bin), .o_invalid(w_month_inv));
  rtc_bcd_decode u_dec_year  (.i_bcd(r_sh_year),               .o_bin(w_year_bin),  .o_invalid(w_year_inv));

  assign w_date_bad = w_day_inv | w_date_inv | w_month_inv | w_year_inv
                    | !in_range(w_day_bin, DAY_MIN, DAY_MAX)
                    | !in_range(w_date_bin, DATE_MIN, DATE_MAX)
                    | !in_range(w_month_bin, MONTH_MIN, MONTH_MAX)
                    | (w_year_bin > YEAR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_day <= 8'd0; r_sh_date <= 8'd0; r_sh_month <= 8'd0; r_sh_year <= 8'd0;
      r_day <= 3'd0; r_date <= 5'd0; r_month <= 4'd0; r_year <= 7'd0;
    end else begin
      if (r_state == ST_WAIT && i2c_done && !i2c_nack) begin
        case (r_idx)
          REG_DAY:   r_sh_day   <= i2c_rdata;
          REG_DATE:  r_sh_date  <= i2c_rdata;
          REG_MONTH: r_sh_month <= i2c_rdata;
          REG_YEAR:  r_sh_year  <= i2c_rdata;
          default:   r_sh_day   <= r_sh_day;
        endcase
      end
      if (r_state == ST_COMMIT) begin
        r_day   <= w_day_bin[2:0];
        r_date  <= w_date_bin[4:0];
        r_month <= w_month_bin[3:0];
        r_year  <= w_year_bin;
      end
    end
  end

  assign day   = r_day;
  assign date  = r_date;
  assign month = r_month;
  assign year  = r_year;
`else
  assign w_date_bad = 1'b0;
`endif

  assign w_invalid = w_time_bad | w_date_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = w_trigger ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (i2c_done) begin
          if (i2c_nack)    w_next_state = ST_ERROR;
          else if (w_last) w_next_state = ST_CHECK;
          else             w_next_state = ST_ISSUE;
        end else if (w_timeout) begin
          w_next_state = ST_ERROR;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_CHECK:  w_next_state = w_invalid ? ST_ERROR : ST_COMMIT;
      ST_COMMIT: w_next_state = ST_IDLE;
      ST_ERROR:  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state.
  always_comb begin
    w_req_nxt  = (w_next_state == ST_WAIT);
    w_busy_nxt = (w_next_state != ST_IDLE);
    w_tv_nxt   = (r_state == ST_COMMIT);
    w_err_nxt  = (r_state == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_cnt <= 32'd0;
      r_to_cnt      <= 32'd0;
      r_idx         <= 3'd0;
      r_err_pend    <= ERR_OK;
      r_reg_addr    <= 8'd0;
      r_sh_sec      <= 8'd0;
      r_sh_min      <= 8'd0;
      r_sh_hour     <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_refresh_cnt <= w_trigger ? 32'd0 : r_refresh_cnt + 32'd1;
          if (w_trigger) r_idx <= 3'd0;
        end
        ST_ISSUE: begin
          r_to_cnt   <= 32'd0;
          r_reg_addr <= {5'd0, r_idx};
        end
        ST_WAIT: begin
          r_to_cnt <= r_to_cnt + 32'd1;
          if (i2c_done) begin
            if (i2c_nack) begin
              r_err_pend <= ERR_NACK;
            end else begin
              case (r_idx)
                REG_SEC:  r_sh_sec  <= i2c_rdata;
                REG_MIN:  r_sh_min  <= i2c_rdata;
                REG_HOUR: r_sh_hour <= i2c_rdata;
                default:  r_sh_sec  <= r_sh_sec;
              endcase
              if (!w_last) r_idx <= r_idx + 3'd1;
            end
          end else if (w_timeout) begin
            r_err_pend <= ERR_TIMEOUT;
          end
        end
        ST_CHECK: begin
          if (w_invalid) r_err_pend <= ERR_INVALID;
        end
        default: begin
          r_refresh_cnt <= r_refresh_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i2c_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_time_valid <= 1'b0;
      r_err        <= 1'b0;
      r_sec        <= 6'd0;
      r_min        <= 6'd0;
      r_hour       <= 5'd0;
      r_clock_halt <= 1'b0;
      r_err_code   <= ERR_OK;
    end else begin
      r_i2c_req    <= w_req_nxt;
      r_busy       <= w_busy_nxt;
      r_time_valid <= w_tv_nxt;
      r_err        <= w_err_nxt;
      if (r_state == ST_COMMIT) begin
        r_sec        <= w_sec_bin[5:0];
        r_min        <= w_min_bin[5:0];
        r_hour       <= w_hour_bin[4:0];
        r_clock_halt <= r_sh_sec[CH_BIT];
        r_err_code   <= ERR_OK;
      end else if (r_state == ST_ERROR) begin
        r_err_code   <= r_err_pend;
      end else begin
        r_err_code   <= r_err_code;
      end
    end
  end

  assign i2c_req      = r_i2c_req;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = r_reg_addr;
  assign sec          = r_sec;
  assign min          = r_min;
  assign hour         = r_hour;
  assign clock_halt   = r_clock_halt;
  assign time_valid   = r_time_valid;
  assign busy         = r_busy;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_rtc_time_reader.sv
// Scoreboard bench for rtc_time_reader: an I2C slave model serves planned bytes,
// the expected outcome of each refresh is queued and checked by an independent monitor.
module tb_rtc_time_reader;

  localparam int unsigned REFRESH = 20;
  localparam int unsigned TMO     = 64;
  localparam int          N       = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       i2c_req;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic [7:0] i2c_rdata = 8'd0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       clock_halt, time_valid, busy, err;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;

  rtc_time_reader #(.REFRESH_CYCLES(REFRESH), .TIMEOUT_CYCLES(TMO), .DEV_ADDR(7'h68)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .sec(sec), .min(min), .hour(hour), .clock_halt(clock_halt),
    .time_valid(time_valid), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // kind: 0 = all bytes returned, 1 = nack at fail_idx, 2 = no answer at fail_idx
  typedef struct {
    logic [2:0][7:0] b;
    int kind;
    int fail_idx;
    int delay;
  } plan_t;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         s, m, h;
    bit         ch;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Reference: decode each register value arithmetically and apply the range rules.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    int v[3];
    bit bad;
    e.is_err = 1'b0; e.code = 2'b00; e.s = 0; e.m = 0; e.h = 0; e.ch = 1'b0;
    if (p.kind == 1) begin e.is_err = 1'b1; e.code = 2'b01; return e; end
    if (p.kind == 2) begin e.is_err = 1'b1; e.code = 2'b10; return e; end
    bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      int x;
      x = int'(p.b[i]);
      if (i < 2) x = x % 128;
      if ((x / 16) > 9 || (x % 16) > 9) bad = 1'b1;
      v[i] = (x / 16) * 10 + (x % 16);
    end
    if (p.b[2][6]) bad = 1'b1;
    if (v[0] > 59 || v[1] > 59 || v[2] > 23) bad = 1'b1;
    if (bad) begin
      e.is_err = 1'b1; e.code = 2'b11;
    end else begin
      e.s = v[0]; e.m = v[1]; e.h = v[2]; e.ch = p.b[0][7];
    end
    return e;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int r, k;
    p.delay    = int'($urandom_range(0, 3));
    r          = int'($urandom_range(0, 19));
    p.kind     = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
    p.fail_idx = int'($urandom_range(0, 2));
    p.b[0]     = to_bcd(int'($urandom_range(0, 59)));
    p.b[1]     = to_bcd(int'($urandom_range(0, 59)));
    p.b[2]     = to_bcd(int'($urandom_range(0, 23)));
    p.b[0][7]  = 1'($urandom_range(0, 1));
    p.b[1][7]  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 5) == 0) begin
      k = int'($urandom_range(0, 2));
      p.b[k] = 8'($urandom_range(0, 255));
    end
    return p;
  endfunction

  task automatic push_plan(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int kind, input int fidx, input int dly);
    plan_t p;
    p.b[0] = b0; p.b[1] = b1; p.b[2] = b2;
    p.kind = kind; p.fail_idx = fidx; p.delay = dly;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic wait_event(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(time_valid || err) && n < 3000);
    chk(name, int'(time_valid || err), 1);
  endtask

  task automatic run(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input int kind, input int fidx, input string name);
    push_plan(b0, b1, b2, kind, fidx, int'($urandom_range(0, 2)));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_event(name);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_req"}, int'(i2c_req), 0);
    chk({name, "_outs"}, int'({sec, min, hour, clock_halt, time_valid, busy, err, err_code}), 0);
  endtask

  // I2C slave model: answers each byte read according to the current plan.
  initial begin : master
    plan_t cur;
    int  cur_idx = 0;
    int  wait_cnt = 0;
    bit  have_plan = 1'b0;
    bit  responded = 1'b0;
    bit  prev_req = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst_n) begin
        cur_idx = 0; wait_cnt = 0; have_plan = 1'b0; responded = 1'b0; prev_req = 1'b0;
      end else begin
        if (i2c_req && !responded) begin
          if (!have_plan) begin
            if (plan_q.size() != 0) cur = plan_q.pop_front();
            else begin
              cur = rand_plan();
              exp_q.push_back(model(cur));
            end
            have_plan = 1'b1;
          end
          if (wait_cnt == 0) chk("reg_addr", int'(i2c_reg_addr), cur_idx);
          if (cur.kind == 2 && cur.fail_idx == cur_idx) begin
            wait_cnt++;
          end else if (wait_cnt < cur.delay) begin
            wait_cnt++;
          end else begin
            i2c_done  = 1'b1;
            responded = 1'b1;
            wait_cnt  = 0;
            if (cur.kind == 1 && cur.fail_idx == cur_idx) begin
              i2c_nack  = 1'b1;
              i2c_rdata = 8'hFF;
              cur_idx   = 0;
              have_plan = 1'b0;
            end else begin
              i2c_rdata = cur.b[cur_idx];
              if (cur_idx == N - 1) begin
                cur_idx   = 0;
                have_plan = 1'b0;
              end else begin
                cur_idx++;
              end
            end
          end
        end else if (!i2c_req) begin
          // request withdrawn without an answer: the refresh timed out
          if (prev_req && !responded) begin
            cur_idx   = 0;
            have_plan = 1'b0;
          end
          responded = 1'b0;
          wait_cnt  = 0;
        end
        prev_req = i2c_req;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int ms = 0, mm = 0, mh = 0, mcode = 0;
    bit mch = 1'b0;
    bit prev_tv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ms = 0; mm = 0; mh = 0; mcode = 0; mch = 1'b0; prev_tv = 1'b0;
      end else begin
        if (time_valid && prev_tv) chk("tv_single_pulse", 1, 0);
        prev_tv = time_valid;
        if (time_valid || err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", int'({time_valid, err}), 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", int'({time_valid, err}), e.is_err ? 1 : 2);
            if (e.is_err) begin
              mcode = int'(e.code);
            end else begin
              ms = e.s; mm = e.m; mh = e.h; mch = e.ch; mcode = 0;
            end
            chk("sec", int'(sec), ms);
            chk("min", int'(min), mm);
            chk("hour", int'(hour), mh);
            chk("clock_halt", int'(clock_halt), int'(mch));
            chk("err_code", int'(err_code), mcode);
            chk("idle_at_event", int'({busy, i2c_req}), 0);
          end
        end
      end
    end
  end

  initial begin : stim
    int cyc;
    bit noisy;
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("dev_addr", int'(i2c_dev_addr), 'h68);
    rst_n = 1'b1;

    cyc = 0;
    while (!i2c_req && cyc < 100) begin @(negedge clk); cyc++; end
    chk("auto_latency", cyc, int'(REFRESH) + 1);
    wait_event("evt_auto");

    // Latency of a refresh with immediate answers: time_valid 2N+3 cycles after start.
    push_plan(8'h45, 8'h30, 8'h12, 0, 0, 0);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      if (cyc == 1) #1 start = 1'b0;
      @(negedge clk);
    end while (!time_valid && !err && cyc < 60);
    chk("start_latency", cyc, 2 * N + 3);

    run(8'hD9, 8'h59, 8'h23, 0, 0, "evt_ch_max");
    run(8'h45, 8'h30, 8'h1A, 0, 0, "evt_bad_hour_nibble");
    run(8'h10, 8'h20, 8'h05, 1, 1, "evt_nack_min");
    run(8'h00, 8'h00, 8'h00, 0, 0, "evt_zero");
    run(8'h00, 8'h00, 8'h52, 0, 0, "evt_12h_mode");
    run(8'h00, 8'h00, 8'h24, 0, 0, "evt_hour_range");
    run(8'h60, 8'h00, 8'h00, 0, 0, "evt_sec_range");
    run(8'h12, 8'hB4, 8'h09, 0, 0, "evt_min_bit7");

    // Timeout with an extra start pulse while busy, which must be dropped.
    push_plan(8'h00, 8'h00, 8'h00, 2, 2, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_event("evt_timeout");
    noisy = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (i2c_req || busy) noisy = 1'b1;
    end
    chk("start_dropped", int'(noisy), 0);

    repeat (40) wait_event("evt_random");

    // Reset in the middle of a read.
    cyc = 0;
    while (!i2c_req && cyc < 200) begin @(negedge clk); cyc++; end
    chk("req_before_reset", int'(i2c_req), 1);
    #2 rst_n = 1'b0;
    plan_q.delete();
    exp_q.delete();
    #1 check_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!i2c_req && cyc < 100) begin @(negedge clk); cyc++; end
    chk("auto_latency_after_reset", cyc, int'(REFRESH) + 1);
    wait_event("evt_after_reset");
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
